div_seq: RTL and testbench

Multi-cycle divide sequencer for the EX stage. It accepts a 32-bit divide request from EX, runs a 32-iteration restoring shift-subtract loop, and holds a stall request to the pipeline control until a 64-bit {remainder, quotient} result is ready. EX owns the request/annul side, and the result is written to HI/LO downstream. The block sequences the single shared divide datapath: one operation in flight at a time.

---
 rtl/div_seq_pkg.sv | 27 ++
 rtl/div_seq_step.sv | 30 +++
 rtl/div_seq.sv | 150 +++++++++++++++
 tb/tb_div_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// Shared definitions for the div_seq divide sequencer. The signed datapath in div_seq is built
// only when DIV_SIGNED_EN is defined.
package div_seq_pkg;

    localparam int unsigned RegBus       = 32;
    localparam int unsigned DoubleRegBus = 64;

    localparam logic [RegBus-1:0] ZeroWord = '0;

    localparam logic RstEnable         = 1'b1;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    function automatic logic [RegBus-1:0] neg_word(input logic [RegBus-1:0] v);
        return ~v + RegBus'(1);
    endfunction

endpackage

// File: rtl/div_seq_step.sv
// One restoring-division iteration: shift {rem, quo} left and trial-subtract the divisor
// from the upper 33 bits.
module div_step
    import div_seq_pkg::*;
(
    input  logic [RegBus-1:0] rem_i,
    input  logic [RegBus-1:0] quo_i,
    input  logic [RegBus-1:0] divisor_i,
    output logic [RegBus-1:0] rem_o,
    output logic [RegBus-1:0] quo_o
);

    logic [RegBus:0]   partial;
    logic [RegBus+1:0] diff;
    logic              borrow;

    assign partial = {rem_i, quo_i[RegBus-1]};
    assign diff    = {1'b0, partial} - {2'b00, divisor_i};
    assign borrow  = diff[RegBus+1];

    // With rem_i < divisor the kept difference always fits in RegBus bits.
    logic unused_diff_msb;
    assign unused_diff_msb = diff[RegBus];

    always_comb begin
        quo_o = {quo_i[RegBus-2:0], ~borrow};
        rem_o = borrow ? partial[RegBus-1:0] : diff[RegBus-1:0];
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle 32-bit divide sequencer with pipeline stall request.
// Define DIV_SIGNED_EN to enable signed (DIV) operation; otherwise all divides are unsigned.
module div_seq
    import div_seq_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    annul_i,
    input  logic                    signed_div_i,
    input  logic [RegBus-1:0]       opdata1_i,
    input  logic [RegBus-1:0]       opdata2_i,
    output logic [DoubleRegBus-1:0] result_o,
    output logic                    ready_o,
    output logic                    stallreq_o
);

    div_state_e              state_q, state_d;
    logic [4:0]              cnt_q, cnt_d;
    logic [RegBus-1:0]       rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [DoubleRegBus-1:0] result_q, result_d;
    logic                    ready_q, ready_d;

    logic [RegBus-1:0] step_rem, step_quo;
    logic [RegBus-1:0] dividend_mag, divisor_mag, fin_rem, fin_quo;
    logic              accept;

    assign accept = (state_q == DivFree) && (start_i == DivStart) && !annul_i;

    div_step u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

`ifdef DIV_SIGNED_EN
    logic op1_neg, op2_neg;
    logic neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

    assign op1_neg      = signed_div_i & opdata1_i[RegBus-1];
    assign op2_neg      = signed_div_i & opdata2_i[RegBus-1];
    assign dividend_mag = op1_neg ? neg_word(opdata1_i) : opdata1_i;
    assign divisor_mag  = op2_neg ? neg_word(opdata2_i) : opdata2_i;
    assign fin_quo      = neg_quo_q ? neg_word(step_quo) : step_quo;
    assign fin_rem      = neg_rem_q ? neg_word(step_rem) : step_rem;

    always_comb begin
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (accept) begin
            neg_quo_d = op1_neg ^ op2_neg;
            neg_rem_d = op1_neg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end
`else
    logic unused_signed;
    assign unused_signed = signed_div_i;
    assign dividend_mag  = opdata1_i;
    assign divisor_mag   = opdata2_i;
    assign fin_quo       = step_quo;
    assign fin_rem       = step_rem;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        result_d = result_q;
        ready_d  = ready_q;
        // Annul outranks iteration and completion in every busy state.
        if (state_q != DivFree && annul_i) begin
            state_d = DivFree;
            ready_d = DivResultNotReady;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                DivFree: begin
                    if (accept) begin
                        dvs_d   = divisor_mag;
                        rem_d   = ZeroWord;
                        quo_d   = dividend_mag;
                        cnt_d   = '0;
                        state_d = (opdata2_i == ZeroWord) ? DivByZero : DivOn;
                    end
                end
                DivByZero: begin
                    state_d  = DivEnd;
                    result_d = '0;
                    ready_d  = DivResultReady;
                end
                DivOn: begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d  = DivEnd;
                        result_d = {fin_rem, fin_quo};
                        ready_d  = DivResultReady;
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        state_d = DivFree;
                        ready_d = DivResultNotReady;
                    end
                end
                default: state_d = DivFree;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q  <= DivFree;
            cnt_q    <= '0;
            rem_q    <= ZeroWord;
            quo_q    <= ZeroWord;
            dvs_q    <= ZeroWord;
            result_q <= '0;
            ready_q  <= DivResultNotReady;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = accept || (state_q == DivByZero) || (state_q == DivOn);

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq; expectations follow DIV_SIGNED_EN when it is defined.
module tb_div_seq;

`ifdef DIV_SIGNED_EN
    localparam bit SignedEn = 1'b1;
`else
    localparam bit SignedEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];

    div_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference divide built on the language's own / and % operators.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        logic        na, nb;
        logic [31:0] ma, mb, q, r;
        if (b == 32'd0) return 64'd0;
        na = SignedEn & s & a[31];
        nb = SignedEn & s & b[31];
        ma = na ? -a : a;
        mb = nb ? -b : b;
        q  = ma / mb;
        r  = ma % mb;
        if (na ^ nb) q = -q;
        if (na) r = -r;
        return {r, q};
    endfunction

    // Called at a negedge with the DUT in FREE; returns at a negedge with the DUT back in FREE.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp, input int exp_lat,
                          input int hold);
        int          lat;
        int          stall_lo;
        logic [63:0] want;
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = s;
        start_i      = 1'b1;
        exp_q.push_back(exp);
        #1;
        check_eq({tag, "/stall_c0"}, 64'(stallreq_o), 64'd1);
        @(posedge clk);
        lat      = 0;
        stall_lo = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!ready_o && !stallreq_o) stall_lo++;
        end while (!ready_o && lat < 100);
        check_eq({tag, "/latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "/stall_busy"}, 64'(stall_lo), 64'd0);
        check_eq({tag, "/stall_end"}, 64'(stallreq_o), 64'd0);
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
        check_eq({tag, "/result"}, result_o, want);
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            check_eq({tag, "/hold_ready"}, 64'(ready_o), 64'd1);
            check_eq({tag, "/hold_result"}, result_o, want);
        end
        start_i = 1'b0;
        @(negedge clk);
        check_eq({tag, "/ready_drop"}, 64'(ready_o), 64'd0);
        check_eq({tag, "/result_keep"}, result_o, want);
        @(negedge clk);
        check_eq({tag, "/idle"}, {62'd0, ready_o, stallreq_o}, 64'd0);
    endtask

    initial begin
        int          ready_seen;
        logic [31:0] ra, rb;

        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        repeat (2) @(negedge clk);
        check_eq("rst/result", result_o, 64'd0);
        check_eq("rst/ready", 64'(ready_o), 64'd0);
        check_eq("rst/stall", 64'(stallreq_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("u100_7", 32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 33, 5);
        run_op("div0", 32'h12345678, 32'h0, 1'b0, 64'd0, 2, 0);
        if (SignedEn) begin
            run_op("s-7_2", 32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 0);
            run_op("smin_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000}, 33, 0);
        end else begin
            run_op("s-7_2", 32'hFFFFFFF9, 32'd2, 1'b1, {32'h1, 32'h7FFFFFFC}, 33, 0);
            run_op("smin_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h80000000, 32'h0}, 33, 0);
        end

        // Annul at cycle 10 of ON.
        opdata1_i    = 32'd100000;
        opdata2_i    = 32'd3;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        check_eq("annul/stall", 64'(stallreq_o), 64'd0);
        check_eq("annul/ready", 64'(ready_o), 64'd0);
        annul_i    = 1'b0;
        ready_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) ready_seen++;
        end
        check_eq("annul/no_ready", 64'(ready_seen), 64'd0);
        run_op("post_annul", 32'hFFFFFFFF, 32'h10, 1'b0, {32'hF, 32'h0FFFFFFF}, 33, 0);

        // Synchronous reset at cycle 20 of an operation.
        opdata1_i = 32'd123456;
        opdata2_i = 32'd11;
        start_i   = 1'b1;
        @(posedge clk);
        repeat (20) @(negedge clk);
        rst     = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        check_eq("midrst/result", result_o, 64'd0);
        check_eq("midrst/ready", 64'(ready_o), 64'd0);
        check_eq("midrst/stall", 64'(stallreq_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        run_op("u9_3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, 0);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom >> (i * 8);
            if (rb == 32'd0) rb = 32'd5;
            run_op($sformatf("rnd%0d", i), ra, rb, i[0], model(ra, rb, i[0]), 33, 0);
        end

        check_eq("sb/empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
